md_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. Consumes rs1/rs2 operand values read from the register file and produces the rd write-back value for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. A radix-2 shift-add or shift-subtract engine completes in 32 iterations. Results are handed to write-back with a one-cycle valid pulse; the pipeline stalls on `busy_o`.

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_unit_if.sv | 26 ++
 rtl/md_iter_core.sv | 68 ++++++
 rtl/md_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES         = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface md_unit_if;
  import md_pkg::*;

  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  busy_o, valid_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output busy_o, valid_o, result_o, rd_addr_o
  );

endinterface

// File: rtl/md_iter_core.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
// The hi/lo pair is the product accumulator for multiply and the
// remainder/quotient pair for divide. Outputs show the values after the
// iteration in progress, so the final result can be captured on the same
// edge as the last step.
module md_iter_core
  import md_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_load,
  input  logic              i_en,
  input  logic              i_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_product,
  output logic [XLEN-1:0]   o_quotient,
  output logic [XLEN-1:0]   o_remainder
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opd;
  logic            r_div;

  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
  always_comb begin
    w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_opd};
    if (r_div) begin
      w_hi_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      w_hi_nxt = w_add[XLEN:1];
      w_lo_nxt = {w_add[0], r_lo[XLEN-1:1]};
    end
  end

  assign o_product   = {w_hi_nxt, w_lo_nxt};
  assign o_quotient  = w_lo_nxt;
  assign o_remainder = w_hi_nxt;

  // Load operands on acceptance, then step once per enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_opd <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_div ? i_a : i_b;
      r_opd <= i_div ? i_b : i_a;
      r_div <= i_div;
    end else if (i_en) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: FSM, iteration counter, sign handling,
// divide special cases and registered write-back outputs.
module md_unit
  import md_pkg::*;
(
  input logic      clk_i,
  input logic      rst_ni,
  md_unit_if.slave bus
);

  md_state_e       r_state;
  md_state_e       w_state_nxt;
  logic [4:0]      r_cnt;
  md_op_e          r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_spec_res;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  md_op_e            w_op;
  logic              w_accept;
  logic              w_finish;
  logic              w_a_signed;
  logic              w_b_signed;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]   w_quotient;
  logic [XLEN-1:0]   w_remainder;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_final;

  assign w_op     = md_op_e'(bus.funct3_i);
  assign w_accept = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign w_finish = (r_state == ST_CALC) && !bus.flush_i && (r_special || (r_cnt == 5'd0));

  // Operand decode at acceptance: signedness, magnitudes and divide special cases.
  always_comb begin
    w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_a_mag    = magnitude(bus.rs1_data_i, w_a_signed);
    w_b_mag    = magnitude(bus.rs2_data_i, w_b_signed);
    w_div_zero = bus.funct3_i[2] && (bus.rs2_data_i == '0);
    w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (bus.rs1_data_i == DIV_OVF_DIVIDEND) && (bus.rs2_data_i == ALL_ONES);
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = bus.funct3_i[1] ? bus.rs1_data_i : ALL_ONES;
    end else if (w_div_ovf) begin
      w_spec_res = bus.funct3_i[1] ? '0 : DIV_OVF_DIVIDEND;
    end
  end

  md_iter_core u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_load      (w_accept),
    .i_en        (r_state == ST_CALC),
    .i_div       (bus.funct3_i[2]),
    .i_a         (w_a_mag),
    .i_b         (w_b_mag),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  // Sign fix and result selection; the quotient sign uses r_neg_q, the remainder follows the dividend.
  always_comb begin
    w_prod_fix = r_neg_q ? (~w_product + 1'b1) : w_product;
    w_final    = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = r_neg_q ? (~w_quotient + 1'b1) : w_quotient;
      OP_REM, OP_REMU:              w_final = r_neg_r ? (~w_remainder + 1'b1) : w_remainder;
      default:                      w_final = '0;
    endcase
    if (r_special) begin
      w_final = r_spec_res;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush aborts any operation in flight and outranks a new start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC: begin
        if (bus.flush_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_special || (r_cnt == 5'd0)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture request context on acceptance, count iterations, register the result on completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_op       <= OP_MUL;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_rd       <= '0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= 5'd31;
        r_op       <= w_op;
        r_neg_q    <= (w_a_signed & bus.rs1_data_i[XLEN-1]) ^ (w_b_signed & bus.rs2_data_i[XLEN-1]);
        r_neg_r    <= w_a_signed & bus.rs1_data_i[XLEN-1];
        r_special  <= w_div_zero || w_div_ovf;
        r_spec_res <= w_spec_res;
        r_rd       <= bus.rd_addr_i;
      end else if ((r_state == ST_CALC) && (r_cnt != 5'd0)) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_finish) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.busy_o    = (r_state != ST_IDLE);
  // A flush arriving during DONE withdraws the pulse in that same cycle.
  assign bus.valid_o   = (r_state == ST_DONE) && !bus.flush_i;
  assign bus.result_o  = r_result;
  assign bus.rd_addr_o = r_rd_out;

endmodule
